// File: rtl/aes_key_sched.sv
// AES-128 key expansion engine: expands a cipher key into 11 round keys,
// one round per clock, and serves them through a registered read port.
// Handshake: start is a one-cycle request, taken only when not busy;
// ready stays high once all keys are valid, until the next start or rst.
// A read takes one cycle: rd_en/rd_round sampled on an edge, and
// rd_key/rd_valid are valid after that same edge.

// Team S-box cell: byte split into 4-bit row and column.
module aes_sbox (
   input  logic [3:0] row,
   input  logic [3:0] col,
   output logic [7:0] sb
);
   logic [127:0] row_bits;

   // One 16-byte line of the S-box per row; the column selects the byte.
   always_comb begin
      row_bits = 128'h0;
      case (row)
         4'h0: row_bits = 128'h637c777bf26b6fc53001672bfed7ab76;
         4'h1: row_bits = 128'hca82c97dfa5947f0add4a2af9ca472c0;
         4'h2: row_bits = 128'hb7fd9326363ff7cc34a5e5f171d83115;
         4'h3: row_bits = 128'h04c723c31896059a071280e2eb27b275;
         4'h4: row_bits = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
         4'h5: row_bits = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
         4'h6: row_bits = 128'hd0efaafb434d338545f9027f503c9fa8;
         4'h7: row_bits = 128'h51a3408f929d38f5bcb6da2110fff3d2;
         4'h8: row_bits = 128'hcd0c13ec5f974417c4a77e3d645d1973;
         4'h9: row_bits = 128'h60814fdc222a908846eeb814de5e0bdb;
         4'ha: row_bits = 128'he0323a0a4906245cc2d3ac629195e479;
         4'hb: row_bits = 128'he7c8376d8dd54ea96c56f4ea657aae08;
         4'hc: row_bits = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
         4'hd: row_bits = 128'h703eb5664803f60e613557b986c11d9e;
         4'he: row_bits = 128'he1f8981169d98e949b1e87e9ce5528df;
         default: row_bits = 128'h8ca1890dbfe6426841992d0fb054bb16;
      endcase
   end

   assign sb = row_bits[8'd127 - {col, 3'b000} -: 8];
endmodule

module aes_key_sched #(
   parameter int NR = 10,
   parameter int KW = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [0:127]  key_in,
   output logic          busy,
   output logic          ready,
   input  logic [3:0]    rd_round,
   input  logic          rd_en,
   output logic [0:127]  rd_key,
   output logic          rd_valid
);
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t       state;
   logic [3:0]   round;
   logic [7:0]   rcon;
   logic [KW-1:0] slots [0:NR];

   logic [3:0]   prev_idx;
   logic [127:0] prev;
   logic [31:0]  rot;
   logic [31:0]  sub;
   logic [31:0]  t;
   logic [31:0]  n0, n1, n2, n3;

   // Previous round key feeding this cycle's expansion step.
   always_comb begin
      prev_idx = (round == 4'd0) ? 4'd0 : round - 4'd1;
      prev     = slots[prev_idx];
   end

   // RotWord: left byte rotation of w3.
   assign rot = {prev[23:0], prev[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sub
      aes_sbox u_sbox (
         .row (rot[31-8*i -: 4]),
         .col (rot[27-8*i -: 4]),
         .sb  (sub[31-8*i -: 8])
      );
   end

   // Word chain of one expansion round.
   always_comb begin
      t  = sub ^ {rcon, 24'h000000};
      n0 = prev[127:96] ^ t;
      n1 = prev[95:64]  ^ n0;
      n2 = prev[63:32]  ^ n1;
      n3 = prev[31:0]   ^ n2;
   end

   // Control FSM, key storage and registered read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         ready    <= 1'b0;
         round    <= 4'd0;
         rcon     <= 8'h01;
         rd_key   <= '0;
         rd_valid <= 1'b0;
         for (int i = 0; i <= NR; i++) slots[i] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  slots[0] <= key_in;
                  round    <= 4'd1;
                  rcon     <= 8'h01;
                  busy     <= 1'b1;
                  ready    <= 1'b0;
                  state    <= EXPAND;
               end
            end
            EXPAND: begin
               slots[round] <= {n0, n1, n2, n3};
               round        <= round + 4'd1;
               rcon         <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
               if (round == 4'(NR)) begin
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase

         // Read sees the slot contents before this edge's write.
         if (rd_en && (rd_round <= 4'(NR))) begin
            rd_key   <= slots[rd_round];
            rd_valid <= 1'b1;
         end else begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_aes_key_sched.sv
// Directed bench for aes_key_sched using FIPS-197 A.1 and all-zero key vectors.
module tb_aes_key_sched;
   logic          clk;
   logic          rst;
   logic          start;
   logic [0:127]  key_in;
   logic          busy;
   logic          ready;
   logic [3:0]    rd_round;
   logic          rd_en;
   logic [0:127]  rd_key;
   logic          rd_valid;

   int pass_cnt;
   int total_cnt;

   typedef struct {
      logic [3:0]   rnd;
      logic [127:0] key;
   } vec_t;

   vec_t         a1_tbl [0:10];
   logic [127:0] exp_q [$];

   localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_ZERO = 128'h0;
   localparam logic [127:0] Z_R1     = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z_R10    = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   aes_key_sched dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .key_in   (key_in),
      .busy     (busy),
      .ready    (ready),
      .rd_round (rd_round),
      .rd_en    (rd_en),
      .rd_key   (rd_key),
      .rd_valid (rd_valid)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Pulse start for one edge; returns just after that edge.
   task automatic do_start(input logic [127:0] k);
      @(negedge clk);
      key_in = k;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   // Counts edges until ready is seen, bounded.
   task automatic wait_ready(output int n);
      n = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (ready) break;
      end
   endtask

   task automatic do_read(input logic [3:0] r, input logic en);
      @(negedge clk);
      rd_round = r;
      rd_en    = en;
      @(posedge clk);
      #1;
      rd_en    = 1'b0;
   endtask

   initial begin
      int n;
      pass_cnt  = 0;
      total_cnt = 0;
      rst       = 1'b0;
      start     = 1'b0;
      key_in    = '0;
      rd_round  = 4'd0;
      rd_en     = 1'b0;

      a1_tbl[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
      a1_tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      a1_tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
      a1_tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
      a1_tbl[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
      a1_tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
      a1_tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
      a1_tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
      a1_tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
      a1_tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
      a1_tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

      // Reset state
      do_reset();
      check("reset_busy",     128'(busy),     128'd0);
      check("reset_ready",    128'(ready),    128'd0);
      check("reset_rd_valid", 128'(rd_valid), 128'd0);
      check("reset_rd_key",   rd_key,         128'd0);

      // A.1 expansion and latency
      do_start(KEY_A1);
      check("a1_busy_after_start", 128'(busy), 128'd1);
      wait_ready(n);
      check("a1_latency", 128'(n), 128'd10);
      check("a1_busy_done", 128'(busy), 128'd0);

      // Back-to-back reads of all rounds, one per cycle
      for (int i = 0; i <= 10; i++) exp_q.push_back(a1_tbl[i].key);
      @(negedge clk);
      for (int i = 0; i <= 10; i++) begin
         rd_round = a1_tbl[i].rnd;
         rd_en    = 1'b1;
         @(posedge clk);
         #1;
         check($sformatf("a1_round_%0d", i), rd_key, exp_q.pop_front());
         check($sformatf("a1_valid_%0d", i), 128'(rd_valid), 128'd1);
         @(negedge clk);
      end
      rd_en = 1'b0;

      // Read port edges
      do_read(4'd11, 1'b1);
      check("oob_valid", 128'(rd_valid), 128'd0);
      check("oob_key",   rd_key,         128'd0);
      do_read(4'd1, 1'b0);
      check("noen_valid", 128'(rd_valid), 128'd0);

      // Restart from DONE with the zero key
      do_start(KEY_ZERO);
      check("restart_ready_low", 128'(ready), 128'd0);
      check("restart_busy",      128'(busy),  128'd1);
      wait_ready(n);
      check("restart_latency", 128'(n), 128'd10);
      do_read(4'd1, 1'b1);
      check("zero_round_1", rd_key, Z_R1);
      do_read(4'd10, 1'b1);
      check("zero_round_10", rd_key, Z_R10);

      // Start during EXPAND is ignored
      do_start(KEY_A1);
      repeat (3) @(posedge clk);
      do_start(KEY_ZERO);
      wait_ready(n);
      check("ignored_start_latency", 128'(n), 128'd6);
      do_read(4'd1, 1'b1);
      check("ignored_round_1", rd_key, a1_tbl[1].key);
      do_read(4'd10, 1'b1);
      check("ignored_round_10", rd_key, A1_R10);

      // Reset mid-expansion
      do_start(KEY_A1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst      = 1'b1;
      rd_round = 4'd1;
      rd_en    = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      rd_en = 1'b0;
      check("midrst_busy",   128'(busy),  128'd0);
      check("midrst_ready",  128'(ready), 128'd0);
      check("midrst_rd_key", rd_key,      128'd0);
      do_read(4'd3, 1'b1);
      check("midrst_round_3", rd_key, 128'd0);
      do_start(KEY_A1);
      wait_ready(n);
      check("post_rst_latency", 128'(n), 128'd10);
      do_read(4'd10, 1'b1);
      check("post_rst_round_10", rd_key, A1_R10);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
